// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: flow codes, FSM states, queue entry.
// Pure declarations; no logic.
package if_fetch_pkg;

    localparam int CPU_WIDTH  = 32;
    localparam int FLOW_WIDTH = 2;
    localparam int BUF_DEPTH  = 2;
    localparam int PTR_W      = 2;

    localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0;
    localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1;
    localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_RESP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0]          inst;
        logic [CPU_WIDTH-1:0] addr;
    } q_entry_t;

    // Fetches are always word reads; low address bits are ignored.
    function automatic logic [CPU_WIDTH-1:0] word_align(input logic [CPU_WIDTH-1:0] a);
        return {a[CPU_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_inst_queue.sv
// Two-entry instruction queue of {inst, addr} with synchronous clear.
// Latency: push visible at head next cycle. Backpressure: caller must not push when full unless popping.
// Clear has priority over push/pop; pointers carry a wrap bit so full/empty need no extra flag.
module if_inst_queue
    import if_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  q_entry_t         push_dat,
    output q_entry_t         head_dat,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    q_entry_t         mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[0]] <= push_dat;
    end

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == 2'd2);
    assign empty    = (wr_ptr == rd_ptr);
    assign head_dat = mem[rd_ptr[0]];

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding word read per curr_pc, results queued two-deep for decode.
// Latency: pc sampled T, gnt T+1, rvalid T+2, inst_valid_o T+3. Backpressure: if_stall_o while busy or queue full.
// IF_PERF_CNT_EN adds perf_fetch_o / perf_stall_o counters.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLOW_WIDTH-1:0] flow_if_i,
    input  logic [CPU_WIDTH-1:0]  curr_pc_i,
    output logic                  ibus_req_o,
    output logic [CPU_WIDTH-1:0]  ibus_addr_o,
    input  logic                  ibus_gnt_i,
    input  logic                  ibus_rvalid_i,
    input  logic [31:0]           ibus_rdata_i,
    output logic [31:0]           inst_o,
    output logic [CPU_WIDTH-1:0]  inst_addr_o,
    output logic                  inst_valid_o,
    input  logic                  id_ready_i,
    output logic                  if_stall_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_o,
    output logic [31:0]           perf_stall_o
`endif
);

    if_state_e            state_q;
    if_state_e            state_nxt;
    logic [CPU_WIDTH-1:0] addr_q;
    logic                 drop_q;
    logic                 latch_pc;

    logic                 flow_work;
    logic                 flow_refresh;
    logic                 rsp_accept;
    logic                 push;
    logic                 pop;
    logic [2:0]           occupancy;
    logic                 launch_ok;

    q_entry_t             head;
    logic                 q_full;
    logic                 q_empty;
    logic [PTR_W-1:0]     q_count;

    // Any code other than WORK/STOP behaves as a refresh.
    assign flow_work    = (flow_if_i == FLOW_WORK);
    assign flow_refresh = (flow_if_i != FLOW_WORK) && (flow_if_i != FLOW_STOP);

    assign rsp_accept = (state_q == IF_RESP) && ibus_rvalid_i;
    assign push       = rsp_accept && !drop_q && !flow_refresh;
    assign pop        = inst_valid_o && id_ready_i;

    // A response landing this cycle still occupies a slot when deciding the next launch.
    assign occupancy = {1'b0, q_count} + {2'b00, push};
    assign launch_ok = flow_work && (occupancy < 3'd2);

    always_comb begin
        state_nxt = state_q;
        latch_pc  = 1'b0;
        case (state_q)
            IF_IDLE: begin
                if (launch_ok) begin
                    state_nxt = IF_REQ;
                    latch_pc  = 1'b1;
                end
            end
            IF_REQ: begin
                if (ibus_gnt_i) state_nxt = IF_RESP;
            end
            IF_RESP: begin
                if (ibus_rvalid_i) begin
                    if (launch_ok) begin
                        state_nxt = IF_REQ;
                        latch_pc  = 1'b1;
                    end else begin
                        state_nxt = IF_IDLE;
                    end
                end
            end
            default: state_nxt = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IF_IDLE;
            addr_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (latch_pc) addr_q <= word_align(curr_pc_i);
            // A refresh while a read is open poisons that read's response.
            if (rsp_accept)
                drop_q <= 1'b0;
            else if (flow_refresh && (state_q != IF_IDLE))
                drop_q <= 1'b1;
        end
    end

    if_inst_queue u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .clear    (flow_refresh),
        .push_dat ('{inst: ibus_rdata_i, addr: addr_q}),
        .head_dat (head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    assign ibus_req_o   = (state_q == IF_REQ);
    assign ibus_addr_o  = addr_q;
    assign inst_valid_o = !q_empty;
    assign inst_o       = q_empty ? NOP_INST : head.inst;
    assign inst_addr_o  = q_empty ? '0 : head.addr;
    assign if_stall_o   = (state_q != IF_IDLE) || q_full;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (push)       perf_fetch_o <= perf_fetch_o + 32'd1;
            if (if_stall_o) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed scenarios plus a randomized run against a transaction-level queue model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  flow_if_i;
    logic [31:0] curr_pc_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic        if_stall_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;
`endif

    int passed = 0;
    int total  = 0;

    if_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flow_if_i     (flow_if_i),
        .curr_pc_i     (curr_pc_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o),
        .id_ready_i    (id_ready_i),
        .if_stall_o    (if_stall_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; flow_if_i = FLOW_STOP; curr_pc_i = '0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0; id_ready_i = 1'b0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flow_if_i = FLOW_WORK; curr_pc_i = 32'h1234_5678;
        ibus_gnt_i = 1'b1; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hFFFF_FFFF; id_ready_i = 1'b1;
        tick; tick;
        chk("reset_req", {31'd0, ibus_req_o}, 32'd0);
        chk("reset_addr", ibus_addr_o, 32'd0);
        chk("reset_inst", inst_o, NOP);
        chk("reset_inst_addr", inst_addr_o, 32'd0);
        chk("reset_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("reset_stall", {31'd0, if_stall_o}, 32'd0);
        do_reset;
    endtask

    task automatic test_basic;
        flow_if_i = FLOW_WORK; curr_pc_i = 32'h0;
        tick;
        flow_if_i = FLOW_STOP; curr_pc_i = 32'hDEAD_BEE0;
        chk("basic_req", {31'd0, ibus_req_o}, 32'd1);
        chk("basic_addr", ibus_addr_o, 32'h0);
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        chk("basic_req_after_gnt", {31'd0, ibus_req_o}, 32'd0);
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h0050_0093;
        chk("basic_valid_early", {31'd0, inst_valid_o}, 32'd0);
        tick; ibus_rvalid_i = 1'b0;
        chk("basic_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("basic_inst", inst_o, 32'h0050_0093);
        chk("basic_inst_addr", inst_addr_o, 32'h0);
        id_ready_i = 1'b1; tick; id_ready_i = 1'b0;
        chk("basic_valid_after_pop", {31'd0, inst_valid_o}, 32'd0);
        chk("basic_nop_after_pop", inst_o, NOP);
    endtask

    task automatic test_gnt_wait;
        flow_if_i = FLOW_WORK; curr_pc_i = 32'h10;
        tick;
        flow_if_i = FLOW_STOP;
        for (int i = 0; i < 4; i++) begin
            curr_pc_i = $urandom;
            chk("wait_req", {31'd0, ibus_req_o}, 32'd1);
            chk("wait_addr", ibus_addr_o, 32'h10);
            tick;
        end
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'h10); tick; ibus_rvalid_i = 1'b0;
        chk("wait_inst_addr", inst_addr_o, 32'h10);
        chk("wait_inst", inst_o, mem_word(32'h10));
        tick;
        chk("wait_single_req", {31'd0, ibus_req_o}, 32'd0);
        id_ready_i = 1'b1; tick; id_ready_i = 1'b0;
    endtask

    task automatic test_backpressure;
        flow_if_i = FLOW_WORK; curr_pc_i = 32'h0; id_ready_i = 1'b0;
        tick;
        curr_pc_i = 32'h4;
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'h0); tick; ibus_rvalid_i = 1'b0;
        curr_pc_i = 32'h8;
        chk("bp_req2", {31'd0, ibus_req_o}, 32'd1);
        chk("bp_addr2", ibus_addr_o, 32'h4);
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'h4); tick; ibus_rvalid_i = 1'b0;
        curr_pc_i = 32'hC;
        for (int i = 0; i < 3; i++) begin
            chk("bp_no_req", {31'd0, ibus_req_o}, 32'd0);
            chk("bp_stall", {31'd0, if_stall_o}, 32'd1);
            chk("bp_head", inst_addr_o, 32'h0);
            tick;
        end
        id_ready_i = 1'b1; tick; id_ready_i = 1'b0;
        chk("bp_head_after_pop", inst_addr_o, 32'h4);
        chk("bp_stall_free", {31'd0, if_stall_o}, 32'd0);
        tick;
        flow_if_i = FLOW_STOP;
        chk("bp_req3", {31'd0, ibus_req_o}, 32'd1);
        chk("bp_addr3", ibus_addr_o, 32'hC);
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'hC); tick; ibus_rvalid_i = 1'b0;
        id_ready_i = 1'b1;
        chk("bp_order4", inst_addr_o, 32'h4);
        tick;
        chk("bp_orderC", inst_addr_o, 32'hC);
        chk("bp_instC", inst_o, mem_word(32'hC));
        tick; id_ready_i = 1'b0;
        chk("bp_drained", {31'd0, inst_valid_o}, 32'd0);
    endtask

    task automatic test_refresh;
        flow_if_i = FLOW_WORK; curr_pc_i = 32'h1C; id_ready_i = 1'b0;
        tick; flow_if_i = FLOW_STOP;
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'h1C); tick; ibus_rvalid_i = 1'b0;
        flow_if_i = FLOW_WORK; curr_pc_i = 32'h20;
        tick; flow_if_i = FLOW_STOP;
        chk("ref_addr", ibus_addr_o, 32'h20);
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        chk("ref_pre_valid", {31'd0, inst_valid_o}, 32'd1);
        flow_if_i = FLOW_REFRESH; tick; flow_if_i = FLOW_STOP;
        chk("ref_cleared", {31'd0, inst_valid_o}, 32'd0);
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'h20); tick; ibus_rvalid_i = 1'b0;
        chk("ref_dropped", {31'd0, inst_valid_o}, 32'd0);
        chk("ref_idle", {31'd0, if_stall_o}, 32'd0);
        flow_if_i = FLOW_WORK; curr_pc_i = 32'h0;
        tick; flow_if_i = FLOW_STOP;
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h0010_0113; tick; ibus_rvalid_i = 1'b0;
        chk("ref_next_addr", inst_addr_o, 32'h0);
        chk("ref_next_inst", inst_o, 32'h0010_0113);
        id_ready_i = 1'b1; tick; id_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back;
        flow_if_i = FLOW_WORK; curr_pc_i = 32'h6; id_ready_i = 1'b0;
        tick;
        curr_pc_i = 32'hB;
        chk("b2b_misaligned", ibus_addr_o, 32'h4);
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'h4); tick; ibus_rvalid_i = 1'b0;
        flow_if_i = FLOW_STOP;
        chk("b2b_req", {31'd0, ibus_req_o}, 32'd1);
        chk("b2b_addr", ibus_addr_o, 32'h8);
        ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'h8); id_ready_i = 1'b1;
        chk("b2b_head4", inst_addr_o, 32'h4);
        tick; ibus_rvalid_i = 1'b0; id_ready_i = 1'b0;
        chk("b2b_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("b2b_head8", inst_addr_o, 32'h8);
        chk("b2b_inst8", inst_o, mem_word(32'h8));
        id_ready_i = 1'b1; tick; id_ready_i = 1'b0;
        chk("b2b_one_entry", {31'd0, inst_valid_o}, 32'd0);
    endtask

    task automatic test_random;
        logic [31:0] exp_inst[$];
        logic [31:0] exp_addr[$];
        logic        prev_req, prev_gnt, inflight, tx_drop, refresh;
        logic [31:0] prev_addr, prev_pc, tx_addr;
        int          dly, r;
        do_reset;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0; prev_pc = '0;
        inflight = 1'b0; tx_drop = 1'b0; tx_addr = '0; dly = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ibus_req_o && !prev_req) chk("rnd_req_addr", ibus_addr_o, {prev_pc[31:2], 2'b00});
            if (prev_req && !prev_gnt) begin
                chk("rnd_req_hold", {31'd0, ibus_req_o}, 32'd1);
                chk("rnd_addr_hold", ibus_addr_o, prev_addr);
            end
            chk("rnd_valid", {31'd0, inst_valid_o}, {31'd0, exp_addr.size() != 0});
            if (inst_valid_o && exp_addr.size() != 0) begin
                chk("rnd_inst", inst_o, exp_inst[0]);
                chk("rnd_inst_addr", inst_addr_o, exp_addr[0]);
            end
            r = $urandom_range(0, 99);
            flow_if_i = (r < 70) ? FLOW_WORK : (r < 90) ? FLOW_STOP : (r < 97) ? FLOW_REFRESH : 2'd3;
            curr_pc_i = $urandom;
            id_ready_i = 1'($urandom_range(0, 1));
            ibus_gnt_i = ibus_req_o && ($urandom_range(0, 2) != 0);
            ibus_rvalid_i = 1'b0; ibus_rdata_i = $urandom;
            if (inflight) begin
                if (dly == 0) begin
                    ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(tx_addr);
                end else begin
                    dly--;
                end
            end
            refresh = (flow_if_i != FLOW_WORK) && (flow_if_i != FLOW_STOP);
            if (inst_valid_o && id_ready_i && exp_addr.size() != 0) begin
                void'(exp_inst.pop_front()); void'(exp_addr.pop_front());
            end
            if (ibus_rvalid_i) begin
                if (!tx_drop && !refresh) begin
                    exp_inst.push_back(mem_word(tx_addr)); exp_addr.push_back(tx_addr);
                end
                inflight = 1'b0; tx_drop = 1'b0;
            end else if (refresh && (ibus_req_o || inflight)) begin
                tx_drop = 1'b1;
            end
            if (refresh) begin
                exp_inst.delete(); exp_addr.delete();
            end
            if (ibus_req_o && ibus_gnt_i) begin
                inflight = 1'b1; tx_addr = ibus_addr_o; dly = $urandom_range(0, 2);
            end
            if (exp_addr.size() > 2) chk("rnd_queue_bound", exp_addr.size(), 32'd2);
            prev_req = ibus_req_o; prev_gnt = ibus_gnt_i; prev_addr = ibus_addr_o; prev_pc = curr_pc_i;
            tick;
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf;
        do_reset;
        chk("perf_fetch_reset", perf_fetch_o, 32'd0);
        chk("perf_stall_reset", perf_stall_o, 32'd0);
        id_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            flow_if_i = FLOW_WORK; curr_pc_i = 32'(i * 4);
            tick; flow_if_i = FLOW_STOP;
            ibus_gnt_i = 1'b1; tick; ibus_gnt_i = 1'b0;
            ibus_rvalid_i = 1'b1; ibus_rdata_i = mem_word(32'(i * 4)); tick; ibus_rvalid_i = 1'b0;
            tick;
        end
        chk("perf_fetch", perf_fetch_o, 32'd5);
        chk("perf_stall", perf_stall_o, 32'd10);
        do_reset;
        chk("perf_fetch_cleared", perf_fetch_o, 32'd0);
        chk("perf_stall_cleared", perf_stall_o, 32'd0);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_gnt_wait;
        test_backpressure;
        test_refresh;
        test_back_to_back;
        test_random;
`ifdef IF_PERF_CNT_EN
        test_perf;
`endif
        test_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
